// File: rtl/ram_pkg.sv
// ============================================================================
// ram_pkg : shared types and byte-merge helper for ram_sdp_stream
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

   typedef enum logic [0:0] {
      READ_FIRST  = 1'b0,
      WRITE_FIRST = 1'b1
   } rd_mode_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   // Per-byte merge; callers apply it lane by lane across the word.
   function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                           input logic [7:0] new_byte,
                                           input logic       be);
      return be ? new_byte : old_byte;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_fwft.sv
// ============================================================================
// fifo_fwft : first-word-fall-through FIFO with occupancy count
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_fwft #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [CW-1:0]    o_count
);

   localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             w_pop;
   logic             w_push;

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == c_LAST) ? '0 : p + 1'b1;
   endfunction

   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && ((r_count != c_FULL) || w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_valid = (r_count != '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(i_push && !w_push));

endmodule

`default_nettype wire

// File: rtl/ram_sdp_stream.sv
// ============================================================================
// ram_sdp_stream : simple-dual-port RAM, byte-enabled writes, streamed
//                  credit-limited reads and a zeroing clear sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_sdp_stream
   import ram_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int WIDTH   = 64,
   parameter int LATENCY = 2,
   parameter int RD_MODE = 0,
   localparam int AW = $clog2(DEPTH),
   localparam int NB = WIDTH / 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [NB-1:0]    wr_be,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_valid,
   output logic             rd_ready,
   input  logic [AW-1:0]    rd_addr,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   input  logic             clr,
   output logic             busy
);

   localparam int            OUT_DEPTH  = LATENCY + 2;
   localparam int            c_CW       = $clog2(OUT_DEPTH + 1);
   localparam logic [c_CW:0] c_OUT_LIM  = (c_CW + 1)'(OUT_DEPTH);
   localparam logic [AW-1:0] c_CLR_LAST = AW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   clr_state_t       r_state;
   logic [AW-1:0]    r_clr_addr;
   logic [LATENCY-1:0] r_pipe_vld;
   logic [WIDTH-1:0] r_pipe_data [LATENCY];
   logic [c_CW-1:0]  r_inflight;

   logic             w_wr_fire;
   logic             w_clr_we;
   logic             w_rd_fire;
   logic             w_push;
   logic             w_pop;
   logic             w_fifo_valid;
   logic [c_CW-1:0]  w_fifo_count;
   logic [c_CW:0]    w_used;
   logic [WIDTH-1:0] w_wr_merged;
   logic [WIDTH-1:0] w_rd_word;

   assign w_wr_fire = wr_en && (r_state == IDLE);
   assign w_clr_we  = (r_state == CLEAR) && !rst;
   assign w_rd_fire = rd_valid && rd_ready;
   assign w_push    = r_pipe_vld[LATENCY-1];
   assign w_pop     = m_valid && m_ready;

   // Counters are registered, so rd_ready never loops back through rd_valid.
   assign w_used   = {1'b0, r_inflight} + {1'b0, w_fifo_count};
   assign rd_ready = !rst && (r_state == IDLE) && (w_used < c_OUT_LIM);
   assign m_valid  = !rst && w_fifo_valid;
   assign busy     = !rst && (r_state == CLEAR);

   always_comb begin
      w_wr_merged = '0;
      for (int i = 0; i < NB; i++) begin
         w_wr_merged[8*i +: 8] = be_merge(r_mem[wr_addr][8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
      end
   end

   // The merged word doubles as the write-first bypass value on a collision.
   if (RD_MODE == int'(WRITE_FIRST)) begin : g_write_first
      assign w_rd_word = (w_wr_fire && (wr_addr == rd_addr)) ? w_wr_merged : r_mem[rd_addr];
   end else begin : g_read_first
      assign w_rd_word = r_mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_clr_addr] <= '0;
      end else if (w_wr_fire) begin
         r_mem[wr_addr] <= w_wr_merged;
      end
   end

   always_ff @(posedge clk) begin
      r_pipe_data[0] <= w_rd_word;
      for (int i = 1; i < LATENCY; i++) begin
         r_pipe_data[i] <= r_pipe_data[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_clr_addr <= '0;
         r_pipe_vld <= '0;
         r_inflight <= '0;
      end else begin
         r_pipe_vld[0] <= w_rd_fire;
         for (int i = 1; i < LATENCY; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
         end

         case ({w_rd_fire, w_push})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase

         case (r_state)
            IDLE: begin
               if (clr) begin
                  r_state    <= CLEAR;
                  r_clr_addr <= '0;
               end
            end
            CLEAR: begin
               if (r_clr_addr == c_CLR_LAST) begin
                  r_state    <= IDLE;
                  r_clr_addr <= '0;
               end else begin
                  r_clr_addr <= r_clr_addr + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   fifo_fwft #(
      .DEPTH (OUT_DEPTH),
      .WIDTH (WIDTH)
   ) u_out_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (r_pipe_data[LATENCY-1]),
      .i_pop   (w_pop),
      .o_valid (w_fifo_valid),
      .o_data  (m_data),
      .o_count (w_fifo_count)
   );

endmodule

`default_nettype wire

// File: tb/tb_ram_sdp_stream.sv
// ============================================================================
// tb_ram_sdp_stream : directed self-checking bench, read-first and write-first
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_sdp_stream;

   localparam int DEPTH   = 16;
   localparam int WIDTH   = 32;
   localparam int LATENCY = 3;
   localparam int AW      = 4;
   localparam int NB      = 4;

   logic             clk      = 1'b0;
   logic             rst      = 1'b1;
   logic             wr_en    = 1'b0;
   logic [AW-1:0]    wr_addr  = '0;
   logic [NB-1:0]    wr_be    = '0;
   logic [WIDTH-1:0] wr_data  = '0;
   logic             rd_valid = 1'b0;
   logic [AW-1:0]    rd_addr  = '0;
   logic             m_ready  = 1'b0;
   logic             clr      = 1'b0;
   logic             rd_ready, m_valid, busy;
   logic             rd_ready1, m_valid1, busy1;
   logic [WIDTH-1:0] m_data, m_data1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ram_sdp_stream #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LATENCY(LATENCY), .RD_MODE(0)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .clr(clr), .busy(busy));

   ram_sdp_stream #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LATENCY(LATENCY), .RD_MODE(1)) dut_wf (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready1), .rd_addr(rd_addr),
      .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .clr(clr), .busy(busy1));

   task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic [NB-1:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic read_one(input logic [AW-1:0] a, output logic [WIDTH-1:0] d0,
                           output logic [WIDTH-1:0] d1, output bit got);
      bit acc = 1'b0;
      got = 1'b0; d0 = '0; d1 = '0;
      rd_valid = 1'b1; rd_addr = a; m_ready = 1'b1;
      for (int k = 0; k < 20 && !acc; k++) begin
         acc = rd_ready;
         @(negedge clk);
      end
      rd_valid = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (m_valid) begin
            got = 1'b1; d0 = m_data; d1 = m_data1;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({rd_ready, m_valid, busy} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_outputs: {rd_ready,m_valid,busy}=%b expected 000", {rd_ready, m_valid, busy});
      end
      n_checks++;
      if ({rd_ready1, m_valid1, busy1} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_outputs_wf: {rd_ready,m_valid,busy}=%b expected 000", {rd_ready1, m_valid1, busy1});
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({rd_ready, m_valid, busy} !== 3'b100) begin
         n_errors++;
         $display("FAIL after_reset: {rd_ready,m_valid,busy}=%b expected 100", {rd_ready, m_valid, busy});
      end
   endtask

   task automatic test_basic_read();
      logic [WIDTH-1:0] d = '0;
      int lat = -1;
      int beats = 0;
      do_write(4'd5, 32'hDEADBEEF, 4'hF);
      rd_valid = 1'b1; rd_addr = 4'd5; m_ready = 1'b1;
      n_checks++;
      if (rd_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL basic_rd_ready: got %b expected 1", rd_ready);
      end
      @(negedge clk);
      rd_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (m_valid && lat < 0) begin
            lat = k; d = m_data;
         end
         if (m_valid) beats++;
         @(negedge clk);
      end
      n_checks++;
      if (lat != 3) begin
         n_errors++;
         $display("FAIL basic_latency: got %0d edges expected 3", lat);
      end
      n_checks++;
      if (d !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL basic_data: got %h expected deadbeef", d);
      end
      n_checks++;
      if (beats != 1) begin
         n_errors++;
         $display("FAIL basic_beats: got %0d expected 1", beats);
      end
   endtask

   task automatic test_byte_enable();
      logic [WIDTH-1:0] d0, d1;
      bit got;
      do_write(4'd5, 32'h0000AA00, 4'b0010);
      read_one(4'd5, d0, d1, got);
      n_checks++;
      if (!got || d0 !== 32'hDEADAAEF) begin
         n_errors++;
         $display("FAIL byte_enable: got %h (valid seen %0d) expected deadaaef", d0, got);
      end
   endtask

   task automatic test_collision();
      logic [WIDTH-1:0] d0 = '0;
      logic [WIDTH-1:0] d1 = '0;
      bit got = 1'b0;
      bit lockstep = 1'b1;
      do_write(4'd3, 32'h11111111, 4'hF);
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h22222222; wr_be = 4'b0011;
      rd_valid = 1'b1; rd_addr = 4'd3; m_ready = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; rd_valid = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         if (m_valid !== m_valid1) lockstep = 1'b0;
         if (m_valid) begin
            got = 1'b1; d0 = m_data; d1 = m_data1;
         end
         @(negedge clk);
      end
      n_checks++;
      if (!got || d0 !== 32'h11111111) begin
         n_errors++;
         $display("FAIL collision_read_first: got %h (valid seen %0d) expected 11111111", d0, got);
      end
      n_checks++;
      if (!got || d1 !== 32'h11112222) begin
         n_errors++;
         $display("FAIL collision_write_first: got %h (valid seen %0d) expected 11112222", d1, got);
      end
      n_checks++;
      if (!lockstep) begin
         n_errors++;
         $display("FAIL collision_lockstep: m_valid differs between modes, expected identical timing");
      end
      read_one(4'd3, d0, d1, got);
      n_checks++;
      if (!got || d0 !== 32'h11112222 || d1 !== 32'h11112222) begin
         n_errors++;
         $display("FAIL collision_stored: got %h/%h expected 11112222/11112222", d0, d1);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] got[$];
      int  n = 0;
      bit  acc;
      bit  hold_bad = 1'b0;
      bit  reassert = 1'b0;
      for (int a = 0; a < 8; a++) do_write(AW'(a), WIDTH'(a), 4'hF);
      m_ready = 1'b0; rd_valid = 1'b1; rd_addr = '0;
      for (int c = 0; c < 10; c++) begin
         acc = rd_ready;
         if (m_valid && m_data !== 32'h0) hold_bad = 1'b1;
         @(negedge clk);
         if (acc) begin
            n++; rd_addr = AW'(n);
         end
      end
      n_checks++;
      if (n != 5) begin
         n_errors++;
         $display("FAIL bp_accepts: got %0d accepts expected 5", n);
      end
      n_checks++;
      if (rd_ready !== 1'b0 || m_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_stall: rd_ready=%b m_valid=%b expected 0/1", rd_ready, m_valid);
      end
      n_checks++;
      if (hold_bad) begin
         n_errors++;
         $display("FAIL bp_hold: m_data moved while stalled, expected stable 00000000");
      end
      m_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (m_valid) got.push_back(m_data);
         acc = rd_valid && rd_ready;
         if (acc) reassert = 1'b1;
         @(negedge clk);
         if (acc) begin
            n++;
            if (n < 8) rd_addr = AW'(n);
            else rd_valid = 1'b0;
         end
      end
      rd_valid = 1'b0;
      n_checks++;
      if (got.size() != 8) begin
         n_errors++;
         $display("FAIL bp_count: got %0d beats expected 8", got.size());
      end
      for (int k = 0; k < got.size() && k < 8; k++) begin
         n_checks++;
         if (got[k] !== WIDTH'(k)) begin
            n_errors++;
            $display("FAIL bp_order[%0d]: got %h expected %h", k, got[k], WIDTH'(k));
         end
      end
      n_checks++;
      if (!reassert) begin
         n_errors++;
         $display("FAIL bp_reassert: rd_ready never returned, expected re-assertion");
      end
   endtask

   task automatic test_clear();
      logic [WIDTH-1:0] d0, d1;
      bit got;
      int cnt = 0;
      bit rdy_bad = 1'b0;
      for (int a = 0; a < DEPTH; a++) do_write(AW'(a), 32'hFFFFFFFF, 4'hF);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_errors++;
         $display("FAIL clr_busy_start: busy=%b expected 1", busy);
      end
      while (busy && cnt < 40) begin
         if (rd_ready) rdy_bad = 1'b1;
         wr_en = (cnt == 10); wr_addr = 4'd2; wr_data = 32'h12345678; wr_be = 4'hF;
         clr = (cnt == 5);
         cnt++;
         @(negedge clk);
      end
      wr_en = 1'b0; clr = 1'b0;
      n_checks++;
      if (cnt != DEPTH) begin
         n_errors++;
         $display("FAIL clr_busy_len: busy for %0d cycles expected %0d", cnt, DEPTH);
      end
      n_checks++;
      if (rdy_bad) begin
         n_errors++;
         $display("FAIL clr_rd_ready: rd_ready=1 seen while busy, expected 0");
      end
      n_checks++;
      if (rd_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL clr_done_ready: rd_ready=%b expected 1", rd_ready);
      end
      for (int a = 0; a < DEPTH; a++) begin
         read_one(AW'(a), d0, d1, got);
         n_checks++;
         if (!got || d0 !== 32'h0) begin
            n_errors++;
            $display("FAIL clr_word[%0d]: got %h (valid seen %0d) expected 00000000", a, d0, got);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [WIDTH-1:0] d0, d1;
      bit got;
      bit stale = 1'b0;
      m_ready = 1'b0; rd_valid = 1'b1; rd_addr = 4'd1;
      @(negedge clk);
      rd_addr = 4'd2;
      @(negedge clk);
      rd_addr = 4'd3; clr = 1'b1;
      @(negedge clk);
      rd_valid = 1'b0; clr = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_errors++;
         $display("FAIL midrst_busy_before: busy=%b expected 1", busy);
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_outputs: m_valid=%b busy=%b expected 0/0", m_valid, busy);
      end
      rst = 1'b0;
      m_ready = 1'b1;
      repeat (10) begin
         if (m_valid) stale = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (stale) begin
         n_errors++;
         $display("FAIL midrst_stale: response beat after reset, expected none");
      end
      read_one(4'd0, d0, d1, got);
      n_checks++;
      if (!got || d0 !== 32'h0) begin
         n_errors++;
         $display("FAIL midrst_newread: got %h (valid seen %0d) expected 00000000", d0, got);
      end
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_byte_enable();
      test_collision();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
